// File: rtl/reg_file_pkg.sv
// Shared width and size constants for the register file, plus the
// record type describing one source-operand query result.
package reg_file_pkg;

  localparam int REG_POS_WID = 5;
  localparam int DATA_WID    = 32;
  localparam int ROB_SIZE    = 16;
  localparam int ROB_POS_WID = $clog2(ROB_SIZE);
  localparam int REG_SIZE    = 32;

  typedef struct packed {
    logic                   busy;
    logic [DATA_WID-1:0]    val;
    logic [ROB_POS_WID-1:0] rob_pos;
  } query_t;

endpackage

// File: rtl/reg_file.sv
// Architectural register file with rename tags: tracks which ROB entry will
// produce each register and forwards a same-cycle commit to both source queries.
module reg_file
  import reg_file_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rdy,
  input  logic                   rollback,
  input  logic                   issue,
  input  logic [REG_POS_WID-1:0] issue_rd,
  input  logic [ROB_POS_WID-1:0] issue_rob_pos,
  input  logic                   reg_write,
  input  logic [REG_POS_WID-1:0] reg_rd,
  input  logic [DATA_WID-1:0]    reg_val,
  input  logic [ROB_POS_WID-1:0] commit_rob_pos,
  input  logic [REG_POS_WID-1:0] rs1_pos,
  input  logic [REG_POS_WID-1:0] rs2_pos,
  output logic                   rs1_busy,
  output logic [DATA_WID-1:0]    rs1_val,
  output logic [ROB_POS_WID-1:0] rs1_rob_pos,
  output logic                   rs2_busy,
  output logic [DATA_WID-1:0]    rs2_val,
  output logic [ROB_POS_WID-1:0] rs2_rob_pos
);

  logic [DATA_WID-1:0]    r_val  [REG_SIZE];
  logic                   r_busy [REG_SIZE];
  logic [ROB_POS_WID-1:0] r_tag  [REG_SIZE];

  query_t w_q1;
  query_t w_q2;

  // Entry 0 is only ever cleared, which hardwires x0 to zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < REG_SIZE; i++) begin
        r_val[i]  <= '0;
        r_busy[i] <= 1'b0;
        r_tag[i]  <= '0;
      end
    end else if (rdy) begin
      for (int i = 1; i < REG_SIZE; i++) begin
        if (reg_write && reg_rd == REG_POS_WID'(i))
          r_val[i] <= reg_val;
        if (rollback) begin
          r_busy[i] <= 1'b0;
          r_tag[i]  <= '0;
        end else if (issue && issue_rd == REG_POS_WID'(i)) begin
          r_busy[i] <= 1'b1;
          r_tag[i]  <= issue_rob_pos;
        end else if (reg_write && reg_rd == REG_POS_WID'(i) &&
                     r_tag[i] == commit_rob_pos) begin
          r_busy[i] <= 1'b0;
        end
      end
    end
  end

  // A commit that retires the current producer is forwarded immediately.
  function automatic query_t lookup(input logic [REG_POS_WID-1:0] pos);
    query_t res;
    logic   hit;
    hit = rdy && reg_write && (pos != '0) && (reg_rd == pos) &&
          r_busy[pos] && (r_tag[pos] == commit_rob_pos);
    res.busy    = r_busy[pos] && !hit;
    res.val     = hit ? reg_val : r_val[pos];
    res.rob_pos = r_tag[pos];
    return res;
  endfunction

  always_comb begin
    w_q1 = lookup(rs1_pos);
    w_q2 = lookup(rs2_pos);
  end

  assign rs1_busy    = w_q1.busy;
  assign rs1_val     = w_q1.val;
  assign rs1_rob_pos = w_q1.rob_pos;
  assign rs2_busy    = w_q2.busy;
  assign rs2_val     = w_q2.val;
  assign rs2_rob_pos = w_q2.rob_pos;

endmodule

// File: tb/tb_reg_file.sv
// Scoreboard bench for reg_file: stimulus queues hand-computed query results,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_reg_file;
  import reg_file_pkg::*;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   rdy;
  logic                   rollback;
  logic                   issue;
  logic [REG_POS_WID-1:0] issue_rd;
  logic [ROB_POS_WID-1:0] issue_rob_pos;
  logic                   reg_write;
  logic [REG_POS_WID-1:0] reg_rd;
  logic [DATA_WID-1:0]    reg_val;
  logic [ROB_POS_WID-1:0] commit_rob_pos;
  logic [REG_POS_WID-1:0] rs1_pos;
  logic [REG_POS_WID-1:0] rs2_pos;
  logic                   rs1_busy;
  logic [DATA_WID-1:0]    rs1_val;
  logic [ROB_POS_WID-1:0] rs1_rob_pos;
  logic                   rs2_busy;
  logic [DATA_WID-1:0]    rs2_val;
  logic [ROB_POS_WID-1:0] rs2_rob_pos;

  typedef struct {
    string                  name;
    bit                     port;
    logic                   busy;
    logic [DATA_WID-1:0]    val;
    logic [ROB_POS_WID-1:0] rob;
  } exp_t;

  exp_t expQ[$];
  int   testsRun = 0;
  int   testsFailed = 0;
  logic [DATA_WID-1:0] expVal [REG_SIZE];

  reg_file dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
    .issue(issue), .issue_rd(issue_rd), .issue_rob_pos(issue_rob_pos),
    .reg_write(reg_write), .reg_rd(reg_rd), .reg_val(reg_val),
    .commit_rob_pos(commit_rob_pos),
    .rs1_pos(rs1_pos), .rs2_pos(rs2_pos),
    .rs1_busy(rs1_busy), .rs1_val(rs1_val), .rs1_rob_pos(rs1_rob_pos),
    .rs2_busy(rs2_busy), .rs2_val(rs2_val), .rs2_rob_pos(rs2_rob_pos)
  );

  always #5 clk = ~clk;

  // Monitor: compare every queued expectation at the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      while (expQ.size() > 0) begin
        exp_t e;
        logic                   aBusy;
        logic [DATA_WID-1:0]    aVal;
        logic [ROB_POS_WID-1:0] aRob;
        e     = expQ.pop_front();
        aBusy = e.port ? rs2_busy    : rs1_busy;
        aVal  = e.port ? rs2_val     : rs1_val;
        aRob  = e.port ? rs2_rob_pos : rs1_rob_pos;
        testsRun++;
        if (aBusy !== e.busy || aVal !== e.val || aRob !== e.rob) begin
          testsFailed++;
          $display("[TB] FAIL %s rs%0d: got busy=%0b val=%h rob=%0d, expected busy=%0b val=%h rob=%0d",
                   e.name, e.port + 1, aBusy, aVal, aRob, e.busy, e.val, e.rob);
        end
      end
    end
  end

  task automatic applyStimulus(input bit iss, input logic [4:0] ird, input logic [3:0] ipos,
                               input bit wr, input logic [4:0] wrd, input logic [31:0] wval,
                               input logic [3:0] cpos, input bit rb);
    issue          = iss;
    issue_rd       = ird;
    issue_rob_pos  = ipos;
    reg_write      = wr;
    reg_rd         = wrd;
    reg_val        = wval;
    commit_rob_pos = cpos;
    rollback       = rb;
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic query(input logic [4:0] p1, input logic [4:0] p2);
    rs1_pos = p1;
    rs2_pos = p2;
  endtask

  task automatic checkOutput(input string name, input bit port, input logic busy,
                             input logic [31:0] val, input logic [3:0] rob);
    exp_t e;
    e.name = name; e.port = port; e.busy = busy; e.val = val; e.rob = rob;
    expQ.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    rdy = 1'b1;
    idle();
    query(5, 0);
    step();
    checkOutput("reset_rs1", 0, 0, 32'h0, 0);
    checkOutput("reset_rs2", 1, 0, 32'h0, 0);
    step();
    rst = 1'b1;
    step();

    // Rename then commit.
    applyStimulus(1, 5, 3, 0, 0, 0, 0, 0);
    query(5, 0);
    checkOutput("issue_invisible_same_cycle", 0, 0, 32'h0, 0);
    step();
    idle();
    checkOutput("rename_busy", 0, 1, 32'h0, 3);
    step();
    applyStimulus(0, 0, 0, 1, 5, 32'hDEADBEEF, 3, 0);
    checkOutput("commit_bypass_rs1", 0, 0, 32'hDEADBEEF, 3);
    step();
    idle();
    checkOutput("commit_written", 0, 0, 32'hDEADBEEF, 3);
    step();

    // Stale commit leaves the newer producer in place.
    applyStimulus(1, 7, 2, 0, 0, 0, 0, 0);
    step();
    applyStimulus(1, 7, 9, 0, 0, 0, 0, 0);
    step();
    applyStimulus(0, 0, 0, 1, 7, 32'h11, 2, 0);
    query(7, 0);
    checkOutput("stale_no_bypass", 0, 1, 32'h0, 9);
    step();
    idle();
    checkOutput("stale_commit", 0, 1, 32'h11, 9);
    step();

    // Same-cycle issue and commit to one register.
    applyStimulus(1, 4, 1, 0, 0, 0, 0, 0);
    step();
    applyStimulus(1, 4, 6, 1, 4, 32'h22, 1, 0);
    query(0, 4);
    checkOutput("issue_commit_bypass", 1, 0, 32'h22, 1);
    step();
    idle();
    checkOutput("issue_commit_newer_wins", 1, 1, 32'h22, 6);
    step();

    // Bypass on rs2 while rs1 watches an unrelated busy register.
    applyStimulus(1, 3, 5, 0, 0, 0, 0, 0);
    step();
    applyStimulus(0, 0, 0, 1, 3, 32'h77, 5, 0);
    query(7, 3);
    checkOutput("bypass_rs2", 1, 0, 32'h77, 5);
    checkOutput("bypass_other_port", 0, 1, 32'h11, 9);
    step();
    idle();
    checkOutput("bypass_committed", 1, 0, 32'h77, 5);
    step();

    // rdy low freezes state and suppresses the bypass.
    rdy = 1'b0;
    applyStimulus(1, 10, 4, 1, 7, 32'h99, 9, 0);
    query(7, 10);
    checkOutput("rdy_low_no_bypass", 0, 1, 32'h11, 9);
    step();
    rdy = 1'b1;
    idle();
    checkOutput("rdy_low_no_write", 0, 1, 32'h11, 9);
    checkOutput("rdy_low_no_issue", 1, 0, 32'h0, 0);
    step();

    // Rollback with concurrent issue and commit.
    for (int i = 1; i < REG_SIZE; i++) begin
      applyStimulus(1, 5'(i), 4'(i), 0, 0, 0, 0, 0);
      step();
    end
    applyStimulus(1, 8, 12, 1, 2, 32'h33, 2, 1);
    query(2, 8);
    checkOutput("rollback_bypass", 0, 0, 32'h33, 2);
    checkOutput("rollback_pre_edge_r8", 1, 1, 32'h0, 8);
    step();
    idle();
    for (int i = 0; i < REG_SIZE; i++) expVal[i] = 32'h0;
    expVal[2] = 32'h33;
    expVal[3] = 32'h77;
    expVal[4] = 32'h22;
    expVal[5] = 32'hDEADBEEF;
    expVal[7] = 32'h11;
    for (int i = 1; i < REG_SIZE; i++) begin
      query(5'(i), 0);
      checkOutput($sformatf("rollback_reg%0d", i), 0, 0, expVal[i], 0);
      step();
    end

    // x0 ignores issue and commit.
    applyStimulus(1, 0, 5, 1, 0, 32'h5, 0, 0);
    query(0, 0);
    checkOutput("x0_same_cycle", 0, 0, 32'h0, 0);
    step();
    idle();
    checkOutput("x0_after", 0, 0, 32'h0, 0);
    step();

    // Asynchronous reset pulsed between edges.
    applyStimulus(1, 9, 7, 0, 0, 0, 0, 0);
    step();
    idle();
    query(9, 5);
    checkOutput("pre_reset_busy", 0, 1, 32'h0, 7);
    step();
    #1;
    rst = 1'b0;
    checkOutput("midreset_rs1", 0, 0, 32'h0, 0);
    checkOutput("midreset_rs2", 1, 0, 32'h0, 0);
    #5;
    rst = 1'b1;
    step();
    checkOutput("post_reset_rs2", 1, 0, 32'h0, 0);
    applyStimulus(1, 6, 1, 0, 0, 0, 0, 0);
    step();
    idle();
    query(6, 0);
    checkOutput("resume_after_reset", 0, 1, 32'h0, 1);
    step();
    step();

    testsRun++;
    if (expQ.size() != 0) begin
      testsFailed++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", expQ.size());
    end
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 SHALL have parameters/constants from the shared macros header: `REG_POS_WID` (5), `DATA_WID` (32), `ROB_POS_WID` (4, ROB_SIZE 16), `REG_SIZE` (32); no module-local parameters.
REQ-002 SHALL have ports:
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- rdy  in  1  global enable; low holds all state.
- rollback  in  1  misprediction flush from the ROB.
- issue  in  1  rename request from the decoder.
- issue_rd  in  `REG_POS_WID`  destination register of the issued instruction.
- issue_rob_pos  in  `ROB_POS_WID`  ROB entry allocated to the issued instruction.
- reg_write  in  1  commit write strobe from the ROB.
- reg_rd  in  `REG_POS_WID`  committed destination register.
- reg_val  in  `DATA_WID`  committed value.
- commit_rob_pos  in  `ROB_POS_WID`  ROB entry being committed.
- rs1_pos / rs2_pos  in  `REG_POS_WID`  source register query.
- rs1_busy / rs2_busy  out  1  source awaits an in-flight result.
- rs1_val / rs2_val  out  `DATA_WID`  architectural value; valid when busy=0.
- rs1_rob_pos / rs2_rob_pos  out  `ROB_POS_WID`  producing ROB entry; valid when busy=1.

Function
REQ-003 SHALL hold 32 entries, each with val[31:0], busy (1 bit) and tag[`ROB_POS_WID`].
REQ-004 SHALL hardwire x0: val 0, busy 0, tag 0; issue and commit targeting x0 are ignored.
REQ-005 SHALL, on issue with issue_rd!=0 and no rollback, set busy[issue_rd]=1 and tag[issue_rd]=issue_rob_pos at the next edge.
REQ-006 SHALL, on reg_write with reg_rd!=0, write val[reg_rd]=reg_val at the next edge, unconditionally.
REQ-007 SHALL clear busy[reg_rd] on commit only if tag[reg_rd]==commit_rob_pos and there is no same-cycle issue to reg_rd.
REQ-008 SHALL, on a same-cycle issue and commit to the same rd, write the value, keep busy=1 and load tag=issue_rob_pos (the newer producer wins).
REQ-009 SHALL, on rollback, clear every busy bit and tag at the next edge, ignore a concurrent issue, and still perform a concurrent reg_write value update.
REQ-010 SHALL produce query outputs combinationally from pre-edge state, with commit bypass applied.
REQ-011 SHALL apply commit bypass: if reg_write, reg_rd==rsN_pos!=0 and tag[rsN_pos]==commit_rob_pos with busy set, then rsN_busy=0 and rsN_val=reg_val.
REQ-012 SHALL make a same-cycle issue invisible to same-cycle queries (an instruction never depends on itself).
REQ-013 SHALL, while rdy=0, ignore issue, reg_write and rollback; queries stay combinational.
REQ-014 SHALL accept one issue and one commit per cycle and insert no stall cycles; commit write latency is 1 cycle.

Reset
REQ-015 SHALL, while rst=0 (asynchronous, regardless of clk and rdy), clear all val, busy and tag to 0.
REQ-016 SHALL drive outputs during reset as: all rsN_busy=0, rsN_val=0, rsN_rob_pos=0.
REQ-017 SHALL discard any operation in progress when reset is asserted mid-operation, and resume at the first edge after reset deassertion.

Structure
REQ-018 SHALL take the width and size constants from the shared macros header; this block adds none.
REQ-019 SHALL be a single module with no sub-module; the two query ports are identical logic (one generate or function permitted).

Verification
REQ-020 SHALL cover rename then commit: issue rd=5 pos=3; query rs1=5 -> busy=1, rob_pos=3; commit rd=5 pos=3 val=0xDEADBEEF -> next cycle busy=0, val=0xDEADBEEF.
REQ-021 SHALL cover a stale commit: issue rd=7 pos=2, then issue rd=7 pos=9; commit rd=7 pos=2 val=0x11 -> val=0x11, busy=1, tag=9.
REQ-022 SHALL cover same-cycle issue and commit to the same rd: issue rd=4 pos=6 with commit rd=4 pos=1 (tag was 1) val=0x22 -> val=0x22, busy=1, tag=6.
REQ-023 SHALL cover bypass: with tag[3]=5 and busy, commit rd=3 pos=5 val=0x77 while querying rs2=3 -> same cycle rs2_busy=0, rs2_val=0x77.
REQ-024 SHALL cover rollback: regs 1..31 busy, rollback=1 with issue rd=8 and commit rd=2 val=0x33 -> next cycle all busy=0, val[2]=0x33, reg 8 not busy.
REQ-025 SHALL cover x0 and reset: issue rd=0 and commit rd=0 val=0x5 -> rs1=0 reads busy=0, val=0; rst=0 pulsed mid-clock -> all outputs 0 immediately, before the next edge.
